// File: rtl/seg_share_arb.sv
// seg_share_arb: round-robin arbiter that time-shares a three-digit seven-segment display
// between four requesters. Each slot shows the owner's 4-bit two's complement value,
// latched at grant, as sign + magnitude digits plus the owner index.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   req      per-requester display request, level-sensitive
//   val      four 4-bit signed values, requester i on val[4i+3:4i]
//   grant    one-hot display owner, zero when idle
//   busy     high while a grant is active
//   o_seg_0  magnitude digit, active-low {a,b,c,d,e,f,g,dp}
//   o_seg_1  sign digit ('-' or blank)
//   o_seg_2  owner index digit
module seg_share_arb #(
  parameter int unsigned DWELL = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] val,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [7:0]  o_seg_0,
  output logic [7:0]  o_seg_1,
  output logic [7:0]  o_seg_2
);

  localparam int unsigned CntW = $clog2(DWELL);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegMinus = 8'hFD;

  typedef enum logic {StIdle, StShow} state_e;

  state_e          state_q;
  logic [3:0]      value_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  // Active-low digit codes, dp always off.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Negation of -8 wraps to 4'b1000, which reads as the unsigned digit 8.
  function automatic logic [3:0] magnitude(input logic [3:0] v);
    return v[3] ? (~v + 4'd1) : v;
  endfunction

  // Round-robin winner: scan ptr+1 .. ptr+4, so the last owner ranks lowest.
  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] win_val;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_val = val[{win_idx, 2'b00} +: 4];
  end

  // In SHOW the pointer always names the current owner.
  logic slot_end;
  assign slot_end = (state_q == StShow) && (!req[ptr_q] || (cnt_q == CntLast));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant   <= 4'b0000;
      value_q <= 4'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      o_seg_0 <= SegBlank;
      o_seg_1 <= SegBlank;
      o_seg_2 <= SegBlank;
    end else if ((state_q == StIdle) || slot_end) begin
      cnt_q <= '0;
      if (win_found) begin
        state_q <= StShow;
        grant   <= 4'b0001 << win_idx;
        value_q <= win_val;
        ptr_q   <= win_idx;
        o_seg_0 <= digit_seg(magnitude(win_val));
        o_seg_1 <= win_val[3] ? SegMinus : SegBlank;
        o_seg_2 <= digit_seg({2'b00, win_idx});
      end else begin
        // Pointer kept so the next arbitration resumes after the last owner.
        state_q <= StIdle;
        grant   <= 4'b0000;
        o_seg_0 <= SegBlank;
        o_seg_1 <= SegBlank;
        o_seg_2 <= SegBlank;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy = |grant;

  grant_onehot_a: assert property (@(posedge clk) $onehot0(grant));
  state_grant_a: assert property (@(posedge clk) (state_q == StShow) == (grant != 4'b0000));

  // value_q documents the displayed value; the decoded digits are registered alongside it.
  logic unused_value;
  assign unused_value = ^value_q;

endmodule

// File: tb/tb_seg_share_arb.sv
module tb_seg_share_arb;

  localparam int unsigned DWELL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] val;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  o_seg_0, o_seg_1, o_seg_2;

  seg_share_arb #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .val     (val),
    .grant   (grant),
    .busy    (busy),
    .o_seg_0 (o_seg_0),
    .o_seg_1 (o_seg_1),
    .o_seg_2 (o_seg_2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_lut [9];

  // Reference model: owner index (-1 = idle), pointer, slot age, latched value.
  int         m_owner;
  int         m_ptr;
  int         m_age;
  logic [3:0] m_val;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] val;
    logic [3:0]  g;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(input logic r, input logic [3:0] rq, input logic [15:0] v);
    int found;
    if (r) begin
      m_owner = -1; m_ptr = 3; m_age = 0; m_val = 4'd0;
    end else if (m_owner < 0 || !rq[m_owner] || m_age == DWELL - 1) begin
      found = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (found < 0 && rq[c]) found = c;
      end
      m_age = 0;
      if (found >= 0) begin
        m_owner = found;
        m_ptr   = found;
        m_val   = v[found*4 +: 4];
      end else begin
        m_owner = -1;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic check_model(input string tag);
    int sv;
    int mag;
    logic [3:0] eg;
    logic [7:0] e0, e1, e2;
    if (m_owner < 0) begin
      eg = 4'b0000; e0 = 8'hFF; e1 = 8'hFF; e2 = 8'hFF;
    end else begin
      sv  = m_val[3] ? int'(m_val) - 16 : int'(m_val);
      mag = (sv < 0) ? -sv : sv;
      eg  = 4'(1 << m_owner);
      e0  = seg_lut[mag];
      e1  = (sv < 0) ? 8'hFD : 8'hFF;
      e2  = seg_lut[m_owner];
    end
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eg != 4'b0000));
    chk({tag, ".seg0"}, 32'(o_seg_0), 32'(e0));
    chk({tag, ".seg1"}, 32'(o_seg_1), 32'(e1));
    chk({tag, ".seg2"}, 32'(o_seg_2), 32'(e2));
  endtask

  // Drive away from the edge, clock once, advance the model, sample 1 time unit later.
  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] v);
    @(negedge clk);
    rst = r; req = rq; val = v;
    @(posedge clk);
    model_tick(r, rq, v);
    #1;
  endtask

  task automatic check_const(input string tag, input logic [3:0] g, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 4'b0000));
    chk({tag, ".seg0"}, 32'(o_seg_0), 32'(s0));
    chk({tag, ".seg1"}, 32'(o_seg_1), 32'(s1));
    chk({tag, ".seg2"}, 32'(o_seg_2), 32'(s2));
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] v,
                              input logic [3:0] g, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2);
    vec_t e;
    e.rst = r; e.req = rq; e.val = v; e.g = g; e.s0 = s0; e.s1 = s1; e.s2 = s2;
    vecs.push_back(e);
  endfunction

  initial begin
    seg_lut[0] = 8'h03; seg_lut[1] = 8'h9F; seg_lut[2] = 8'h25;
    seg_lut[3] = 8'h0D; seg_lut[4] = 8'h99; seg_lut[5] = 8'h49;
    seg_lut[6] = 8'h41; seg_lut[7] = 8'h1F; seg_lut[8] = 8'h01;
    m_owner = -1; m_ptr = 3; m_age = 0; m_val = 4'd0;
    rst = 1'b1; req = 4'b0000; val = 16'h0000;

    // Single requester, -3, val changed mid-slot, then re-grant with fresh value.
    add(1, 4'b0000, 16'h0000, 4'b0000, 8'hFF, 8'hFF, 8'hFF);
    add(0, 4'b0001, 16'h000D, 4'b0001, 8'h0D, 8'hFD, 8'h03);
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 16'h0000, 4'b0001, 8'h0D, 8'hFD, 8'h03);
    add(0, 4'b0001, 16'h0000, 4'b0001, 8'h03, 8'hFF, 8'h03);
    // -8 shows magnitude 8, then +7 on the following slot.
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 16'h0008, 4'b0001, 8'h03, 8'hFF, 8'h03);
    add(0, 4'b0001, 16'h0008, 4'b0001, 8'h01, 8'hFD, 8'h03);
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 16'h0007, 4'b0001, 8'h01, 8'hFD, 8'h03);
    add(0, 4'b0001, 16'h0007, 4'b0001, 8'h1F, 8'hFF, 8'h03);
    // All four requesting: rotation 0,1,2,3,0, DWELL cycles each, no gap.
    add(1, 4'b1111, 16'h4321, 4'b0000, 8'hFF, 8'hFF, 8'hFF);
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < DWELL; c++)
        add(0, 4'b1111, 16'h4321, 4'(1 << (s % 4)), seg_lut[(s % 4) + 1], 8'hFF,
            seg_lut[s % 4]);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].val);
      check_const($sformatf("vec%0d", i), vecs[i].g, vecs[i].s0, vecs[i].s1, vecs[i].s2);
    end

    // Early release by owner 2 at cnt=1, then drop to idle.
    step(1, 4'b0000, 16'h0000);
    step(0, 4'b1100, 16'h5A00);
    check_const("rel.grant2", 4'b0100, 8'h41, 8'hFD, 8'h25);
    step(0, 4'b1100, 16'h5A00);
    check_const("rel.hold", 4'b0100, 8'h41, 8'hFD, 8'h25);
    step(0, 4'b1000, 16'h5A00);
    check_const("rel.grant3", 4'b1000, 8'h49, 8'hFF, 8'h0D);
    step(0, 4'b0000, 16'h5A00);
    check_const("rel.idle", 4'b0000, 8'hFF, 8'hFF, 8'hFF);

    // Reset mid-slot while owner 2 holds the display.
    step(1, 4'b0000, 16'h0000);
    for (int i = 0; i < 2 * DWELL + 1; i++) step(0, 4'b1111, 16'h1111);
    check_const("rst.pre", 4'b0100, 8'h9F, 8'hFF, 8'h25);
    step(1, 4'b1111, 16'h1111);
    check_const("rst.abort", 4'b0000, 8'hFF, 8'hFF, 8'hFF);
    step(0, 4'b1111, 16'h1111);
    check_const("rst.first", 4'b0001, 8'h9F, 8'hFF, 8'h03);

    // Randomised traffic against the model.
    begin
      logic [3:0] rq;
      int hold;
      rq = 4'b0000;
      hold = 0;
      for (int i = 0; i < 600; i++) begin
        if (hold == 0) begin
          rq   = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
          hold = $urandom_range(1, 9);
        end
        hold--;
        step(($urandom_range(0, 63) == 0), rq, 16'($urandom));
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
